layer2_mac_engine: RTL and testbench

Clocked consumer that sits directly downstream of the ReLU node queue and replaces the combinational multStore path. It pops ReLU node values one at a time and fetches the matching Layer-2 weight row by node index. It multiply-accumulates each popped value into all Layer-2 output node accumulators in parallel. Zero-valued ReLU nodes are skipped without a weight fetch.

---
 rtl/layer2_mac_engine.sv | 135 +++++++++++++
 tb/tb_layer2_mac_engine.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer2_mac_engine.sv
// rtl/layer2_mac_engine.sv - Layer-2 MAC engine draining the ReLU node queue
// Pops ReLU nodes, fetches the matching weight row, saturating-MACs into every output node.
module layer2_mac_engine #(
    parameter int RELU_NODES       = 64,
    parameter int RELU_INDEX_WIDTH = 7,
    parameter int IN_WIDTH         = 8,
    parameter int WEIGHT_WIDTH     = 8,
    parameter int OUT_NODES        = 10,
    parameter int ACC_WIDTH        = 24
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              start,
    input  logic                              queue_empty,
    input  logic [RELU_INDEX_WIDTH-1:0]       relu_index,
    input  logic [IN_WIDTH-1:0]               relu_value,
    output logic                              dequeue,
    output logic [RELU_INDEX_WIDTH-1:0]       weight_addr,
    output logic                              weight_rd,
    input  logic [OUT_NODES*WEIGHT_WIDTH-1:0] weight_data,
    output logic [OUT_NODES*ACC_WIDTH-1:0]    acc_out,
    output logic                              busy,
    output logic                              done,
    output logic                              result_valid,
    output logic                              overflow
);
    localparam int CNT_W  = $clog2(RELU_NODES + 1);
    localparam int PROD_W = IN_WIDTH + WEIGHT_WIDTH + 1;
    localparam int SUM_W  = ACC_WIDTH + 1;

    typedef enum logic [2:0] {IDLE, CHECK, POP_HI, POP_LO, FETCH, ACC, DONE} state_t;

    state_t                      state;
    state_t                      nextState;
    logic [CNT_W-1:0]            popCount;
    logic [IN_WIDTH-1:0]         valueReg;
    logic [RELU_INDEX_WIDTH-1:0] addrReg;
    logic                        resultValidReg;
    logic                        overflowReg;
    logic [ACC_WIDTH-1:0]        accReg  [OUT_NODES];
    logic [ACC_WIDTH-1:0]        accNext [OUT_NODES];
    logic [OUT_NODES-1:0]        satHit;
    logic                        popLimit;

    assign popLimit     = (popCount == CNT_W'(RELU_NODES));
    assign weight_addr  = addrReg;
    assign result_valid = resultValidReg;
    assign overflow     = overflowReg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // The pop limit guards against a queue that never reports empty.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = CHECK;
            CHECK:   nextState = (queue_empty || popLimit) ? DONE : POP_HI;
            POP_HI:  nextState = POP_LO;
            POP_LO:  nextState = (relu_value == '0) ? CHECK : FETCH;
            FETCH:   nextState = ACC;
            ACC:     nextState = CHECK;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        dequeue   = 1'b0;
        weight_rd = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE:    busy = 1'b0;
            POP_HI:  dequeue = 1'b1;
            FETCH:   weight_rd = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    for (genvar n = 0; n < OUT_NODES; n++) begin : g_node
        logic signed [WEIGHT_WIDTH-1:0] weight;
        logic signed [PROD_W-1:0]       product;
        logic signed [SUM_W-1:0]        sum;

        assign weight  = weight_data[(OUT_NODES-1-n)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        assign product = PROD_W'($signed({1'b0, valueReg})) * PROD_W'(weight);
        assign sum     = SUM_W'($signed(accReg[n])) + SUM_W'(product);
        // One guard bit: top two bits disagree exactly when the sum left the accumulator range.
        assign satHit[n]  = sum[SUM_W-1] != sum[SUM_W-2];
        assign accNext[n] = !satHit[n]   ? sum[ACC_WIDTH-1:0] :
                            sum[SUM_W-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} :
                                           {1'b0, {(ACC_WIDTH-1){1'b1}}};
        assign acc_out[(OUT_NODES-1-n)*ACC_WIDTH +: ACC_WIDTH] = accReg[n];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            popCount       <= '0;
            valueReg       <= '0;
            addrReg        <= '0;
            resultValidReg <= 1'b0;
            overflowReg    <= 1'b0;
            for (int n = 0; n < OUT_NODES; n++) accReg[n] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        popCount       <= '0;
                        resultValidReg <= 1'b0;
                        overflowReg    <= 1'b0;
                        for (int n = 0; n < OUT_NODES; n++) accReg[n] <= '0;
                    end
                end
                POP_HI: popCount <= popCount + CNT_W'(1);
                POP_LO: begin
                    valueReg <= relu_value;
                    if (relu_value != '0) addrReg <= relu_index;
                end
                ACC: begin
                    for (int n = 0; n < OUT_NODES; n++) accReg[n] <= accNext[n];
                    if (|satHit) overflowReg <= 1'b1;
                end
                default: ;
            endcase
            if (nextState == DONE) resultValidReg <= 1'b1;
        end
    end
endmodule

// File: tb/tb_layer2_mac_engine.sv
// tb/tb_layer2_mac_engine.sv - bench for layer2_mac_engine
module tb_layer2_mac_engine;
    localparam int NR = 4, IW = 7, INW = 8, WW = 8, ON = 10, AWA = 24, AWB = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic queue_empty;
    logic [IW-1:0] relu_index = '0;
    logic [INW-1:0] relu_value = '0;
    logic [ON*WW-1:0] weight_data = '0;
    logic deqA, rdA, busyA, doneA, rvA, ovfA;
    logic deqB, rdB, busyB, doneB, rvB, ovfB;
    logic [IW-1:0] addrA, addrB;
    logic [ON*AWA-1:0] accA;
    logic [ON*AWB-1:0] accB;

    always #5 clk = ~clk;

    layer2_mac_engine #(.RELU_NODES(NR), .RELU_INDEX_WIDTH(IW), .IN_WIDTH(INW),
        .WEIGHT_WIDTH(WW), .OUT_NODES(ON), .ACC_WIDTH(AWA)) dutA (
        .clk(clk), .reset_n(reset_n), .start(start), .queue_empty(queue_empty),
        .relu_index(relu_index), .relu_value(relu_value), .dequeue(deqA),
        .weight_addr(addrA), .weight_rd(rdA), .weight_data(weight_data), .acc_out(accA),
        .busy(busyA), .done(doneA), .result_valid(rvA), .overflow(ovfA));

    layer2_mac_engine #(.RELU_NODES(NR), .RELU_INDEX_WIDTH(IW), .IN_WIDTH(INW),
        .WEIGHT_WIDTH(WW), .OUT_NODES(ON), .ACC_WIDTH(AWB)) dutB (
        .clk(clk), .reset_n(reset_n), .start(start), .queue_empty(queue_empty),
        .relu_index(relu_index), .relu_value(relu_value), .dequeue(deqB),
        .weight_addr(addrB), .weight_rd(rdB), .weight_data(weight_data), .acc_out(accB),
        .busy(busyB), .done(doneB), .result_valid(rvB), .overflow(ovfB));

    // ReLU queue: data latched on the rising edge of dequeue, pointer advances on the falling edge.
    int qLen = 0;
    int qPtr = 0;
    logic qReset = 1'b0;
    logic [INW-1:0] qVals [8];
    assign queue_empty = (qPtr >= qLen);
    always @(posedge deqA) begin
        relu_index <= IW'(qPtr);
        relu_value <= qVals[qPtr & 7];
    end
    always @(negedge deqA or posedge qReset) begin
        if (qReset) qPtr <= 0;
        else        qPtr <= qPtr + 1;
    end

    logic signed [WW-1:0] wMem [8][ON];
    always @(posedge clk) begin
        if (rdA) for (int n = 0; n < ON; n++) weight_data[(ON-1-n)*WW +: WW] <= wMem[addrA[2:0]][n];
    end

    int cyc = 0, deqTotal = 0, deqWide = 0, rdTotal = 0, doneCyc = -1, ctrlDiff = 0;
    int rdLog [64];
    logic prevDeq = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        prevDeq <= deqA;
        if (deqA) deqTotal <= deqTotal + 1;
        if (deqA && prevDeq) deqWide <= deqWide + 1;
        if (rdA) begin
            rdLog[rdTotal % 64] <= int'(addrA);
            rdTotal <= rdTotal + 1;
        end
        if (doneA) doneCyc <= cyc;
        if (deqA !== deqB || rdA !== rdB || doneA !== doneB || busyA !== busyB) ctrlDiff <= ctrlDiff + 1;
    end

    int nAssert = 0, nFail = 0;
    task automatic check(input string name, input longint act, input longint exp);
        nAssert++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint getA(input int n);
        return longint'($signed(accA[(ON-1-n)*AWA +: AWA]));
    endfunction
    function automatic longint getB(input int n);
        return longint'($signed(accB[(ON-1-n)*AWB +: AWB]));
    endfunction

    // Reference: walk the queue contents in order, saturating add per node.
    longint expA [ON];
    longint expB [ON];
    bit expOA, expOB;
    int expDone, expPops;
    int expRd [$];

    function automatic longint clampAdd(input longint a, input longint p, input int w, inout bit ov);
        longint hi = (longint'(1) <<< (w - 1)) - 1;
        longint lo = -(longint'(1) <<< (w - 1));
        longint s = a + p;
        if (s > hi) begin ov = 1'b1; return hi; end
        if (s < lo) begin ov = 1'b1; return lo; end
        return s;
    endfunction

    task automatic runModel();
        expPops = (qLen < NR) ? qLen : NR;
        expDone = 2;
        expOA = 1'b0;
        expOB = 1'b0;
        expRd.delete();
        for (int n = 0; n < ON; n++) begin expA[n] = 0; expB[n] = 0; end
        for (int i = 0; i < expPops; i++) begin
            int v = int'(qVals[i]);
            if (v == 0) expDone += 3;
            else begin
                expDone += 5;
                expRd.push_back(i);
                for (int n = 0; n < ON; n++) begin
                    longint p = longint'(v) * longint'(wMem[i][n]);
                    expA[n] = clampAdd(expA[n], p, AWA, expOA);
                    expB[n] = clampAdd(expB[n], p, AWB, expOB);
                end
            end
        end
    endtask

    task automatic setWeights(input int mode);
        for (int r = 0; r < 8; r++)
            for (int n = 0; n < ON; n++) begin
                case (mode)
                    0: case (r)
                           0: wMem[r][n] = 8'sd2;
                           2: wMem[r][n] = -8'sd1;
                           3: wMem[r][n] = (n == 0) ? 8'sd127 : 8'sd0;
                           default: wMem[r][n] = WW'($urandom);
                       endcase
                    1: wMem[r][n] = 8'sd127;
                    2: wMem[r][n] = -8'sd128;
                    default: wMem[r][n] = WW'($urandom);
                endcase
            end
    endtask

    task automatic loadQueue(input int len);
        qLen = len;
        qReset = 1'b1;
        #1;
        qReset = 1'b0;
    endtask

    int startCyc, deq0, rd0, wide0, cd0;
    task automatic startPass();
        @(negedge clk); #1;
        start = 1'b1;
        startCyc = cyc; deq0 = deqTotal; rd0 = rdTotal; wide0 = deqWide; cd0 = ctrlDiff;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int injectAt);
        int k = 0;
        while (doneA !== 1'b1 && k < 300) begin
            start = (injectAt != 0 && (cyc - startCyc) == injectAt);
            @(negedge clk); #1;
            k++;
        end
        start = 1'b0;
        if (doneA !== 1'b1) check("done_timeout", 0, 1);
    endtask

    task automatic checkPass(input string tag);
        check({tag, " done_cycle"}, doneCyc - startCyc, expDone);
        for (int n = 0; n < ON; n++) begin
            check($sformatf("%s accA[%0d]", tag, n), getA(n), expA[n]);
            check($sformatf("%s accB[%0d]", tag, n), getB(n), expB[n]);
        end
        check({tag, " overflowA"}, ovfA, expOA);
        check({tag, " overflowB"}, ovfB, expOB);
        check({tag, " result_valid_at_done"}, rvA, 1);
        check({tag, " dequeue_pulses"}, deqTotal - deq0, expPops);
        check({tag, " dequeue_wide"}, deqWide - wide0, 0);
        check({tag, " front_pointer"}, qPtr, expPops);
        check({tag, " weight_rd_count"}, rdTotal - rd0, expRd.size());
        for (int i = 0; i < expRd.size() && i < rdTotal - rd0; i++)
            check($sformatf("%s weight_addr[%0d]", tag, i), rdLog[(rd0 + i) % 64], expRd[i]);
        check({tag, " ctrl_A_vs_B"}, ctrlDiff - cd0, 0);
        @(negedge clk); #1;
        check({tag, " busy_after"}, busyA, 0);
        check({tag, " done_pulse_len"}, doneA, 0);
        check({tag, " result_valid_hold"}, rvA, 1);
    endtask

    typedef struct {
        int len;
        int vals [6];
        int wmode;
        longint a0A, arA;
        bit oA;
        longint a0B, arB;
        bit oB;
        int dCyc;
        int nRd;
    } vec_t;
    vec_t vecs [5];

    task automatic runVec(input int idx, input int injectAt);
        for (int i = 0; i < 6; i++) qVals[i] = INW'(vecs[idx].vals[i]);
        setWeights(vecs[idx].wmode);
        loadQueue(vecs[idx].len);
        runModel();
        expA[0] = vecs[idx].a0A; expB[0] = vecs[idx].a0B;
        for (int n = 1; n < ON; n++) begin expA[n] = vecs[idx].arA; expB[n] = vecs[idx].arB; end
        expOA = vecs[idx].oA; expOB = vecs[idx].oB; expDone = vecs[idx].dCyc;
        startPass();
        waitDone(injectAt);
        check($sformatf("vec%0d rd_count_table", idx), rdTotal - rd0, vecs[idx].nRd);
        checkPass($sformatf("vec%0d", idx));
    endtask

    initial begin
        vecs[0] = '{len: 4, vals: '{3, 0, 5, 1, 0, 0}, wmode: 0, a0A: 128, arA: 1, oA: 0,
                    a0B: 128, arB: 1, oB: 0, dCyc: 20, nRd: 3};
        vecs[1] = '{len: 0, vals: '{0, 0, 0, 0, 0, 0}, wmode: 0, a0A: 0, arA: 0, oA: 0,
                    a0B: 0, arB: 0, oB: 0, dCyc: 2, nRd: 0};
        vecs[2] = '{len: 4, vals: '{255, 255, 255, 255, 0, 0}, wmode: 1, a0A: 129540, arA: 129540, oA: 0,
                    a0B: 32767, arB: 32767, oB: 1, dCyc: 22, nRd: 4};
        vecs[3] = '{len: 4, vals: '{255, 255, 255, 255, 0, 0}, wmode: 2, a0A: -130560, arA: -130560, oA: 0,
                    a0B: -32768, arB: -32768, oB: 1, dCyc: 22, nRd: 4};
        vecs[4] = '{len: 6, vals: '{1, 2, 3, 4, 5, 6}, wmode: 1, a0A: 1270, arA: 1270, oA: 0,
                    a0B: 1270, arB: 1270, oB: 0, dCyc: 22, nRd: 4};

        for (int i = 0; i < 8; i++) qVals[i] = '0;
        setWeights(0);
        loadQueue(0);
        repeat (3) @(negedge clk);
        #1;
        check("reset accA", (accA == '0), 1);
        check("reset accB", (accB == '0), 1);
        check("reset dequeue", deqA, 0);
        check("reset weight_rd", rdA, 0);
        check("reset weight_addr", addrA, 0);
        check("reset busy", busyA, 0);
        check("reset done", doneA, 0);
        check("reset result_valid", rvA, 0);
        check("reset overflow", ovfA, 0);
        @(negedge clk); #1;
        reset_n = 1'b1;

        for (int v = 0; v < 5; v++) runVec(v, 0);

        runVec(0, 8);
        loadQueue(4);
        startPass();
        check("restart accA cleared", (accA == '0), 1);
        check("restart result_valid cleared", rvA, 0);
        waitDone(0);
        runModel();
        checkPass("restart");

        for (int i = 0; i < 6; i++) qVals[i] = INW'(vecs[0].vals[i]);
        setWeights(0);
        loadQueue(4);
        startPass();
        begin
            int k = 0;
            while (rdTotal - rd0 < 2 && k < 200) begin @(negedge clk); #1; k++; end
            check("abort reached second fetch", rdTotal - rd0, 2);
        end
        @(negedge clk); #1;
        check("abort pre-reset acc nonzero", (accA != '0), 1);
        reset_n = 1'b0;
        #1;
        check("abort accA", (accA == '0), 1);
        check("abort accB", (accB == '0), 1);
        check("abort dequeue", deqA, 0);
        check("abort busy", busyA, 0);
        check("abort overflow", ovfA, 0);
        check("abort result_valid", rvA, 0);
        @(negedge clk); #1;
        reset_n = 1'b1;
        runVec(0, 0);

        for (int t = 0; t < 25; t++) begin
            int len = $urandom_range(0, 6);
            for (int i = 0; i < 8; i++)
                qVals[i] = ($urandom_range(0, 2) == 0) ? INW'(0) : INW'($urandom_range(1, 255));
            setWeights(3);
            loadQueue(len);
            runModel();
            startPass();
            waitDone(0);
            checkPass($sformatf("rand%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
